// File: rtl/floating_point_multiplier_seq.sv
// Sequential IEEE-style floating-point multiplier: shift-add significand
// product, single-cycle normalise/round, special-operand bypass, no subnormals.
module floating_point_multiplier_seq #(
  parameter int unsigned EXPONENT_WIDTH = 8,
  parameter int unsigned MANTISSA_WIDTH = 23
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] a,
  input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] b,
  input  logic [1:0]                             round_mode,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] out,
  output logic                                   underflow_flag,
  output logic                                   overflow_flag,
  output logic                                   invalid_operation_flag
);

  localparam int unsigned E       = EXPONENT_WIDTH;
  localparam int unsigned M       = MANTISSA_WIDTH;
  localparam int unsigned W       = E + M + 1;
  localparam int unsigned PW      = 2 * (M + 1);
  localparam int unsigned XW      = E + 2;
  localparam int unsigned CW      = $clog2(M + 1);
  localparam int unsigned BIAS    = (1 << (E - 1)) - 1;
  localparam int unsigned EXP_INF = (1 << E) - 1;

  localparam logic [E-1:0] EXP_ONES   = E'(EXP_INF);
  localparam logic [E-1:0] EXP_MAXF   = E'(EXP_INF - 1);
  localparam logic [M-1:0] MANT_QUIET = M'(1) << (M - 1);
  localparam logic [M-1:0] MANT_ONES  = '1;

  localparam logic [1:0] RM_RNE = 2'd0;
  localparam logic [1:0] RM_RUP = 2'd2;
  localparam logic [1:0] RM_RDN = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d;
  logic [1:0]      rm_q, rm_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   mcand_q, mcand_d;
  logic [M:0]      mplier_q, mplier_d;
  logic [PW-1:0]   prod_q, prod_d;
  logic [W-1:0]    out_q, out_d;
  logic            uf_q, uf_d, of_q, of_d, inv_q, inv_d;
  logic            out_valid_q, out_valid_d;
  logic            in_ready_q, in_ready_d;

  // Operand field decode of the captured operands
  logic         sa, sb, sp;
  logic [E-1:0] ea, eb;
  logic [M-1:0] fa, fb;
  logic         a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, a_sub, b_sub;

  assign sa     = a_q[W-1];
  assign sb     = b_q[W-1];
  assign sp     = sa ^ sb;
  assign ea     = a_q[W-2:M];
  assign eb     = b_q[W-2:M];
  assign fa     = a_q[M-1:0];
  assign fb     = b_q[M-1:0];
  assign a_nan  = (ea == EXP_ONES) && (fa != '0);
  assign b_nan  = (eb == EXP_ONES) && (fb != '0);
  assign a_inf  = (ea == EXP_ONES) && (fa == '0);
  assign b_inf  = (eb == EXP_ONES) && (fb == '0);
  assign a_zero = (ea == '0) && (fa == '0);
  assign b_zero = (eb == '0) && (fb == '0);
  assign a_sub  = (ea == '0) && (fa != '0);
  assign b_sub  = (eb == '0) && (fb != '0);

  // Special-operand result, in priority order; spec_hit bypasses the datapath
  logic         spec_hit;
  logic [W-1:0] spec_res;
  logic         spec_uf, spec_of, spec_inv;

  always_comb begin
    spec_hit = 1'b1;
    spec_res = '0;
    spec_uf  = 1'b0;
    spec_of  = 1'b0;
    spec_inv = 1'b0;
    if (a_nan) begin
      spec_inv = 1'b1;
      spec_res = fa[M-1] ? a_q : {sa, EXP_ONES, MANT_QUIET};
    end else if (b_nan) begin
      spec_inv = 1'b1;
      spec_res = fb[M-1] ? b_q : {sb, EXP_ONES, MANT_QUIET};
    end else if ((a_inf && (b_zero || b_sub)) || (b_inf && (a_zero || a_sub))) begin
      spec_inv = 1'b1;
      spec_res = {1'b0, EXP_ONES, MANT_QUIET};
    end else if (a_inf || b_inf) begin
      spec_of  = 1'b1;
      spec_res = {sp, EXP_ONES, {M{1'b0}}};
    end else if (a_sub || b_sub) begin
      spec_uf  = 1'b1;
      spec_res = {sp, {(W-1){1'b0}}};
    end else if (a_zero || b_zero) begin
      spec_res = {sp, {(W-1){1'b0}}};
    end else begin
      spec_hit = 1'b0;
    end
  end

  // Normalise, round and range-check the finished significand product
  logic          norm_hi;
  logic [PW-2:0] norm_sig;
  logic [M-1:0]  mant_raw;
  logic          guard, sticky, round_up, rnd_carry, to_inf;
  logic [M+1:0]  sig_rnd;
  logic [M-1:0]  mant_fin;
  logic [XW-1:0] exp_sum;
  logic          exp_uf, exp_of;
  logic [W-1:0]  norm_res;

  always_comb begin
    norm_hi  = prod_q[PW-1];
    norm_sig = norm_hi ? prod_q[PW-2:0] : {prod_q[PW-3:0], 1'b0};
    mant_raw = norm_sig[PW-2 -: M];
    guard    = norm_sig[M];
    sticky   = |norm_sig[M-1:0];
    round_up = 1'b0;
    unique case (rm_q)
      RM_RNE:  round_up = guard && (sticky || mant_raw[0]);
      RM_RUP:  round_up = !sp && (guard || sticky);
      RM_RDN:  round_up = sp && (guard || sticky);
      default: round_up = 1'b0;
    endcase
    sig_rnd   = {1'b0, 1'b1, mant_raw} + (M+2)'(round_up);
    rnd_carry = sig_rnd[M+1];
    mant_fin  = rnd_carry ? sig_rnd[M:1] : sig_rnd[M-1:0];
    exp_sum   = XW'(ea) + XW'(eb) - XW'(BIAS) + XW'(norm_hi) + XW'(rnd_carry);
    // Sign bit of exp_sum is valid: the true range never reaches +/-2^(XW-1)
    exp_uf    = exp_sum[XW-1] || (exp_sum == '0);
    exp_of    = !exp_sum[XW-1] && (exp_sum[XW-2:0] >= (XW-1)'(EXP_INF));
    to_inf    = (rm_q == RM_RNE) || ((rm_q == RM_RUP) && !sp) || ((rm_q == RM_RDN) && sp);
    if (exp_uf) begin
      norm_res = {sp, {(W-1){1'b0}}};
    end else if (exp_of) begin
      norm_res = to_inf ? {sp, EXP_ONES, {M{1'b0}}} : {sp, EXP_MAXF, MANT_ONES};
    end else begin
      norm_res = {sp, exp_sum[E-1:0], mant_fin};
    end
  end

  // Next-state and datapath update for the IDLE/MULT/NORM/DONE sequence
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    rm_d        = rm_q;
    cnt_d       = cnt_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    prod_d      = prod_q;
    out_d       = out_q;
    uf_d        = uf_q;
    of_d        = of_q;
    inv_d       = inv_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d      = a;
          b_d      = b;
          rm_d     = round_mode;
          cnt_d    = '0;
          prod_d   = '0;
          mcand_d  = PW'({1'b1, a[M-1:0]});
          mplier_d = {1'b1, b[M-1:0]};
          state_d  = MULT;
        end
      end
      MULT: begin
        // Specials resolve on the first MULT cycle and skip the iterations
        if ((cnt_q == '0) && spec_hit) begin
          out_d       = spec_res;
          uf_d        = spec_uf;
          of_d        = spec_of;
          inv_d       = spec_inv;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          prod_d   = prod_q + (mplier_q[0] ? mcand_q : PW'(0));
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + CW'(1);
          if (cnt_q == CW'(M)) begin
            state_d = NORM;
          end
        end
      end
      NORM: begin
        out_d       = norm_res;
        uf_d        = exp_uf;
        of_d        = exp_of;
        inv_d       = 1'b0;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = (state_d == IDLE);
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      rm_q        <= '0;
      cnt_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      prod_q      <= '0;
      out_q       <= '0;
      uf_q        <= 1'b0;
      of_q        <= 1'b0;
      inv_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      rm_q        <= rm_d;
      cnt_q       <= cnt_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      prod_q      <= prod_d;
      out_q       <= out_d;
      uf_q        <= uf_d;
      of_q        <= of_d;
      inv_q       <= inv_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready               = in_ready_q;
  assign out_valid              = out_valid_q;
  assign out                    = out_q;
  assign underflow_flag         = uf_q;
  assign overflow_flag          = of_q;
  assign invalid_operation_flag = inv_q;

endmodule

// File: tb/tb_floating_point_multiplier_seq.sv
// Bench for floating_point_multiplier_seq (binary32 configuration).
module tb_floating_point_multiplier_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic [1:0]  round_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out;
  logic        underflow_flag, overflow_flag, invalid_operation_flag;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  floating_point_multiplier_seq #(
    .EXPONENT_WIDTH(8),
    .MANTISSA_WIDTH(23)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .in_valid               (in_valid),
    .in_ready               (in_ready),
    .a                      (a),
    .b                      (b),
    .round_mode             (round_mode),
    .out_valid              (out_valid),
    .out_ready              (out_ready),
    .out                    (out),
    .underflow_flag         (underflow_flag),
    .overflow_flag          (overflow_flag),
    .invalid_operation_flag (invalid_operation_flag)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  rm;
    logic [31:0] r;
    logic [2:0]  fl;
    int          lat;
  } vec_t;

  // Reference model: exact integer product, rounding decided from the remainder
  function automatic void ref_mul(input logic [31:0] x, input logic [31:0] y,
                                  input logic [1:0] rm,
                                  output logic [31:0] r, output logic [2:0] fl,
                                  output int lat);
    logic sx, sy, s, up;
    logic [7:0] ex, ey;
    logic [22:0] fx, fy;
    longint unsigned p, q, rem, half;
    int sh, e;
    sx = x[31]; sy = y[31]; s = sx ^ sy;
    ex = x[30:23]; ey = y[30:23];
    fx = x[22:0]; fy = y[22:0];
    lat = 1;
    if (ex == 8'hFF && fx != 0) begin
      r = fx[22] ? x : {sx, 8'hFF, 23'h400000}; fl = 3'b001;
    end else if (ey == 8'hFF && fy != 0) begin
      r = fy[22] ? y : {sy, 8'hFF, 23'h400000}; fl = 3'b001;
    end else if ((ex == 8'hFF && ey == 0) || (ey == 8'hFF && ex == 0)) begin
      r = 32'h7FC00000; fl = 3'b001;
    end else if (ex == 8'hFF || ey == 8'hFF) begin
      r = {s, 8'hFF, 23'h0}; fl = 3'b010;
    end else if ((ex == 0 && fx != 0) || (ey == 0 && fy != 0)) begin
      r = {s, 31'h0}; fl = 3'b100;
    end else if (ex == 0 || ey == 0) begin
      r = {s, 31'h0}; fl = 3'b000;
    end else begin
      lat  = 25;
      p    = (64'(fx) | (64'd1 << 23)) * (64'(fy) | (64'd1 << 23));
      sh   = (p >= (64'd1 << 47)) ? 24 : 23;
      q    = p >> sh;
      rem  = p - (q << sh);
      half = 64'd1 << (sh - 1);
      e    = int'(ex) + int'(ey) - 127 + (sh - 23);
      case (rm)
        2'd0:    up = (rem > half) || (rem == half && q[0]);
        2'd1:    up = 1'b0;
        2'd2:    up = !s && rem != 0;
        default: up = s && rem != 0;
      endcase
      q = q + 64'(up);
      if (q == (64'd1 << 24)) begin
        q = q >> 1;
        e = e + 1;
      end
      if (e <= 0) begin
        r = {s, 31'h0}; fl = 3'b100;
      end else if (e >= 255) begin
        fl = 3'b010;
        if (rm == 2'd0 || (rm == 2'd2 && !s) || (rm == 2'd3 && s)) r = {s, 8'hFF, 23'h0};
        else r = {s, 8'hFE, 23'h7FFFFF};
      end else begin
        r = {s, e[7:0], q[22:0]}; fl = 3'b000;
      end
    end
  endfunction

  function automatic logic [31:0] rand_operand();
    logic [31:0] v;
    int k;
    v = $urandom;
    k = $urandom_range(0, 11);
    case (k)
      0: v[30:0] = '0;
      1: begin v[30:23] = 8'hFF; v[22:0] = '0; end
      2: begin v[30:23] = 8'hFF; if (v[22:0] == 0) v[0] = 1'b1; end
      3: begin v[30:23] = 8'h00; if (v[22:0] == 0) v[0] = 1'b1; end
      4: v[30:23] = 8'($urandom_range(1, 12));
      5: v[30:23] = 8'($urandom_range(243, 254));
      6: begin v[30:23] = 8'($urandom_range(100, 150)); v[22:0] = 23'h7FFFFF ^ 23'($urandom_range(0, 3)); end
      default: v[30:23] = 8'($urandom_range(90, 164));
    endcase
    return v;
  endfunction

  // Issue one operation and wait (bounded) for its result
  task automatic run_op(input logic [31:0] ia, input logic [31:0] ib, input logic [1:0] rm,
                        output logic [31:0] r, output logic [2:0] fl, output int lat);
    int w;
    w = 0;
    while (in_ready !== 1'b1 && w < 200) begin
      @(posedge clk); #1; w++;
    end
    a = ia; b = ib; round_mode = rm; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = $urandom; b = $urandom; round_mode = 2'($urandom);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    r  = out;
    fl = {underflow_flag, overflow_flag, invalid_operation_flag};
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    a = 32'h40400000; b = 32'h40800000; round_mode = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else passed++;
    total++; if (out !== 32'h0) $display("FAIL reset_out: got %h want 00000000", out); else passed++;
    total++;
    if ({underflow_flag, overflow_flag, invalid_operation_flag} !== 3'b000)
      $display("FAIL reset_flags: got %b want 000", {underflow_flag, overflow_flag, invalid_operation_flag});
    else passed++;
    rst = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    total++; if (in_ready !== 1'b1) $display("FAIL post_reset_idle: got %b want 1", in_ready); else passed++;
  endtask

  task automatic test_directed();
    vec_t dv[14];
    logic [31:0] r;
    logic [2:0] fl;
    int lat;
    dv[0]  = '{32'h40400000, 32'h40800000, 2'd0, 32'h41400000, 3'b000, 25};
    dv[1]  = '{32'h3F800001, 32'h3F800001, 2'd0, 32'h3F800002, 3'b000, 25};
    dv[2]  = '{32'h3F800001, 32'h3F800001, 2'd1, 32'h3F800002, 3'b000, 25};
    dv[3]  = '{32'h3F800001, 32'h3F800001, 2'd2, 32'h3F800003, 3'b000, 25};
    dv[4]  = '{32'h3F800001, 32'h3F800001, 2'd3, 32'h3F800002, 3'b000, 25};
    dv[5]  = '{32'h7F7FFFFF, 32'h40000000, 2'd0, 32'h7F800000, 3'b010, 25};
    dv[6]  = '{32'h7F7FFFFF, 32'h40000000, 2'd1, 32'h7F7FFFFF, 3'b010, 25};
    dv[7]  = '{32'h00000000, 32'h7F800000, 2'd0, 32'h7FC00000, 3'b001, 1};
    dv[8]  = '{32'hFFA00000, 32'h40800000, 2'd0, 32'hFFC00000, 3'b001, 1};
    dv[9]  = '{32'h00000001, 32'h00000001, 2'd0, 32'h00000000, 3'b100, 1};
    dv[10] = '{32'h7F800000, 32'h00000000, 2'd0, 32'h7FC00000, 3'b001, 1};
    dv[11] = '{32'h7FC12345, 32'h3F800000, 2'd0, 32'h7FC12345, 3'b001, 1};
    dv[12] = '{32'hBF800000, 32'h00000000, 2'd0, 32'h80000000, 3'b000, 1};
    dv[13] = '{32'hC0000000, 32'h7F800000, 2'd1, 32'hFF800000, 3'b010, 1};
    for (int i = 0; i < 14; i++) begin
      run_op(dv[i].a, dv[i].b, dv[i].rm, r, fl, lat);
      total++; if (r !== dv[i].r) $display("FAIL directed%0d_out: got %h want %h", i, r, dv[i].r); else passed++;
      total++; if (fl !== dv[i].fl) $display("FAIL directed%0d_flags: got %b want %b", i, fl, dv[i].fl); else passed++;
      total++; if (lat != dv[i].lat) $display("FAIL directed%0d_latency: got %0d want %0d", i, lat, dv[i].lat); else passed++;
      release_out();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] r;
    logic [2:0] fl;
    int lat;
    run_op(32'h40400000, 32'h40800000, 2'd0, r, fl, lat);
    total++; if (r !== 32'h41400000) $display("FAIL bp_out: got %h want 41400000", r); else passed++;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++;
      if ({out_valid, in_ready, underflow_flag, overflow_flag, invalid_operation_flag, out} !== {1'b1, 1'b0, 3'b000, 32'h41400000})
        $display("FAIL bp_hold%0d: got v=%b rdy=%b fl=%b out=%h want v=1 rdy=0 fl=000 out=41400000", i,
                 out_valid, in_ready, {underflow_flag, overflow_flag, invalid_operation_flag}, out);
      else passed++;
    end
    // Offer a new operand on the release edge: it must not be taken that edge
    a = 32'h3F800000; b = 32'h3F800000; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    total++;
    if ({in_ready, out_valid} !== 2'b10)
      $display("FAIL bp_release: got rdy=%b v=%b want rdy=1 v=0", in_ready, out_valid);
    else passed++;
  endtask

  task automatic test_reset_abort();
    logic [31:0] r;
    logic [2:0] fl;
    int lat, seen;
    a = 32'h40400000; b = 32'h40800000; round_mode = 2'd0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    total++; if (out_valid !== 1'b0) $display("FAIL abort_out_valid: got %b want 0", out_valid); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL abort_in_ready: got %b want 1", in_ready); else passed++;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen++;
    end
    total++; if (seen != 0) $display("FAIL abort_no_result: got %0d valid cycles want 0", seen); else passed++;
    run_op(32'h40400000, 32'h40800000, 2'd0, r, fl, lat);
    total++; if (r !== 32'h41400000) $display("FAIL abort_next_out: got %h want 41400000", r); else passed++;
    total++; if (fl !== 3'b000) $display("FAIL abort_next_flags: got %b want 000", fl); else passed++;
    total++; if (lat != 25) $display("FAIL abort_next_latency: got %0d want 25", lat); else passed++;
    release_out();
  endtask

  task automatic test_random();
    logic [31:0] ra, rb, r, er;
    logic [1:0] rm;
    logic [2:0] fl, efl;
    int lat, elat;
    for (int i = 0; i < 150; i++) begin
      ra = rand_operand();
      rb = rand_operand();
      rm = 2'($urandom_range(0, 3));
      ref_mul(ra, rb, rm, er, efl, elat);
      run_op(ra, rb, rm, r, fl, lat);
      total++;
      if (r !== er) $display("FAIL rand%0d_out: a=%h b=%h rm=%0d got %h want %h", i, ra, rb, rm, r, er);
      else passed++;
      total++;
      if (fl !== efl) $display("FAIL rand%0d_flags: a=%h b=%h rm=%0d got %b want %b", i, ra, rb, rm, fl, efl);
      else passed++;
      total++;
      if (lat != elat) $display("FAIL rand%0d_latency: got %0d want %0d", i, lat, elat);
      else passed++;
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      release_out();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_abort();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/floating_point_multiplier_seq.md
FLOATING_POINT_MULTIPLIER_SEQ -- requirements
Module: floating_point_multiplier_seq

Interface
REQ-001 SHALL have parameter EXPONENT_WIDTH, default 8, exponent field width E.
REQ-002 SHALL have parameter MANTISSA_WIDTH, default 23, stored mantissa width M; float width W = E+M+1.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have ports in_valid (input, 1) and in_ready (output, 1): operand handshake.
REQ-006 SHALL have ports a and b (input, W): operands. round_mode (input, 2): 0=RNE, 1=RTZ, 2=RUP (toward +Inf), 3=RDN (toward -Inf).
REQ-007 SHALL have ports out_valid (output, 1) and out_ready (input, 1): result handshake.
REQ-008 SHALL have port out (output, W): product.
REQ-009 SHALL have ports underflow_flag, overflow_flag and invalid_operation_flag (output, 1 each), valid with out.

Function
REQ-010 SHALL implement FSM IDLE -> MULT -> NORM -> DONE -> IDLE; in_ready = 1 only in IDLE.
REQ-011 SHALL accept a transfer on an edge with in_valid & in_ready, capturing a, b and round_mode; later input changes SHALL have no effect.
REQ-012 SHALL form the (M+1)x(M+1) significand product by iterative shift-add, one multiplier bit per cycle, M+1 cycles in MULT, using a cycle counter.
REQ-013 SHALL normalise and round in NORM in one cycle, using guard bit plus sticky OR of all lower product bits.
REQ-014 SHALL compute exponent = ea + eb - (2^(E-1)-1), +1 if product >= 2.0, +1 more on a rounding carry-out; sign = sa XOR sb.
REQ-015 SHALL assert out_valid M+2 cycles after the accepting edge for finite nonzero operands, and 1 cycle after it for special cases (REQ-018..REQ-022), which bypass MULT and NORM.
REQ-016 SHALL hold out, out_valid and flags stable in DONE while out_ready = 0; on an edge with out_ready = 1 it SHALL return to IDLE, with in_ready high the following cycle and no same-cycle re-accept.
REQ-017 SHALL produce no subnormal outputs. A biased result exponent <= 0 after rounding gives signed zero with underflow_flag = 1.
REQ-018 SHALL treat a subnormal operand (exp = 0, mantissa != 0) as signed zero and set underflow_flag.
REQ-019 SHALL handle exponent overflow (>= 2^E - 1): set overflow_flag and output Inf for RNE, for RUP if positive, and for RDN if negative; otherwise output max finite (exp 2^E-2, mantissa all ones) with the result sign.
REQ-020 SHALL handle Inf x nonzero-finite or Inf x Inf: output signed Inf with overflow_flag = 1.
REQ-021 SHALL handle a NaN operand (a checked first): set invalid_operation_flag. A QNaN SHALL be passed through unchanged; an SNaN SHALL become sign | exp all ones | only mantissa MSB set.
REQ-022 SHALL handle 0 x Inf (either order): output canonical QNaN (sign 0, exp all ones, mantissa MSB only) with invalid_operation_flag = 1.
REQ-023 SHALL handle zero x finite: output signed zero with all flags 0.
REQ-024 SHALL set every flag not named by the applicable rule to 0.

Reset
REQ-025 SHALL, on an edge with rst = 1, enter IDLE, clear out, all flags, out_valid and internal accumulator/counter, and drive in_ready = 1 from the next cycle.
REQ-026 SHALL let rst abort any in-flight operation: no out_valid is produced for it, and rst has priority over every handshake on the same edge.

Verification
REQ-027 SHALL test: a=40400000, b=40800000, RNE -> out=41400000, flags 000, out_valid exactly 25 cycles after accept.
REQ-028 SHALL test: a=b=3F800001 -> RNE 3F800002, RTZ 3F800002, RUP 3F800003, RDN 3F800002; flags 000.
REQ-029 SHALL test: a=7F7FFFFF, b=40000000 -> RNE 7F800000 and RTZ 7F7FFFFF, overflow_flag=1 in both.
REQ-030 SHALL test specials: 00000000 x 7F800000 -> 7FC00000 inv=1; FFA00000 x 40800000 -> FFC00000 inv=1 after 1 cycle; 00000001 x 00000001 -> 00000000 uf=1.
REQ-031 SHALL test backpressure: hold out_ready=0 for 5 cycles after out_valid -> out and flags unchanged and in_ready=0; release -> IDLE next cycle.
REQ-032 SHALL test reset: assert rst during MULT cycle 10 -> out_valid=0, in_ready=1 next cycle; the next operation 3.0x4.0 completes correctly.
